// File: rtl/bbox_ctrl.sv
// Frame-level bounding-box tracker: counts active pixels per frame, qualifies the
// box reported by the detection engine, tracks consecutive misses and publishes via valid/ready.
module bbox_ctrl #(
    parameter int IMG_W       = 720,
    parameter int IMG_H       = 576,
    parameter int MIN_SIZE    = 4,
    parameter int LOST_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vsync,
    input  logic        de,
    input  logic [9:0]  bb_x_min,
    input  logic [9:0]  bb_x_max,
    input  logic [9:0]  bb_y_min,
    input  logic [9:0]  bb_y_max,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [9:0]  o_x_min,
    output logic [9:0]  o_x_max,
    output logic [9:0]  o_y_min,
    output logic [9:0]  o_y_max,
    output logic        o_found,
    output logic        o_lost,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  err_cnt
);

    localparam int                MISS_W    = $clog2(LOST_FRAMES + 1);
    localparam logic [19:0]       FRAME_PIX = 20'(IMG_W * IMG_H);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(LOST_FRAMES);
    localparam logic [10:0]       MIN_SZ    = 11'(MIN_SIZE);

    typedef enum logic [2:0] {
        IDLE, WAIT_SOF, ACTIVE, CAPTURE, EVAL, PUBLISH
    } state_t;

    state_t            state_q, state_d;
    logic              vsync_q;
    logic [19:0]       pix_q, pix_d;
    logic [9:0]        x_min_q, x_min_d, x_max_q, x_max_d;
    logic [9:0]        y_min_q, y_min_d, y_max_q, y_max_d;
    logic              found_q, found_d, lost_q, lost_d;
    logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
    logic [15:0]       frame_q, frame_d;
    logic [7:0]        drop_q, drop_d, err_q, err_d;

    logic        eof, sof, box_found;
    logic [10:0] w_x, w_y;

    always_comb begin
        eof       = vsync_q & ~vsync;
        sof       = ~vsync_q & vsync;
        // 11-bit extents; only meaningful when max >= min, which box_found also requires
        w_x       = {1'b0, bb_x_max} - {1'b0, bb_x_min} + 11'd1;
        w_y       = {1'b0, bb_y_max} - {1'b0, bb_y_min} + 11'd1;
        box_found = (bb_x_max >= bb_x_min) && (bb_y_max >= bb_y_min) &&
                    (w_x >= MIN_SZ) && (w_y >= MIN_SZ);
        miss_inc  = (miss_q == MISS_MAX) ? miss_q : miss_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        x_min_d = x_min_q;
        x_max_d = x_max_q;
        y_min_d = y_min_q;
        y_max_d = y_max_q;
        found_d = found_q;
        lost_d  = lost_q;
        miss_d  = miss_q;
        frame_d = frame_q;
        drop_d  = drop_q;
        err_d   = err_q;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            if (state_q != IDLE) begin
                if (sof)
                    pix_d = 20'd0;
                else if (vsync && de)
                    pix_d = pix_q + 20'd1;
            end

            case (state_q)
                IDLE:     state_d = WAIT_SOF;
                WAIT_SOF: if (sof) state_d = ACTIVE;
                ACTIVE:   if (eof) state_d = CAPTURE;
                CAPTURE:  state_d = EVAL;
                EVAL: begin
                    if (pix_q != FRAME_PIX) begin
                        err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                        state_d = WAIT_SOF;
                    end else begin
                        frame_d = frame_q + 16'd1;
                        state_d = PUBLISH;
                        if (box_found) begin
                            x_min_d = bb_x_min;
                            x_max_d = bb_x_max;
                            y_min_d = bb_y_min;
                            y_max_d = bb_y_max;
                            found_d = 1'b1;
                            miss_d  = '0;
                            lost_d  = 1'b0;
                        end else begin
                            found_d = 1'b0;
                            miss_d  = miss_inc;
                            lost_d  = (miss_inc == MISS_MAX);
                            if (miss_inc == MISS_MAX) begin
                                x_min_d = 10'd0;
                                x_max_d = 10'd0;
                                y_min_d = 10'd0;
                                y_max_d = 10'd0;
                            end
                        end
                    end
                end
                PUBLISH: begin
                    // A frame ending while the previous result is still unclaimed is lost
                    if (eof)
                        drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                    if (o_ready)
                        state_d = vsync ? ACTIVE : WAIT_SOF;
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            pix_q   <= '0;
            x_min_q <= '0;
            x_max_q <= '0;
            y_min_q <= '0;
            y_max_q <= '0;
            found_q <= 1'b0;
            lost_q  <= 1'b0;
            miss_q  <= '0;
            frame_q <= '0;
            drop_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            pix_q   <= pix_d;
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_min_q <= y_min_d;
            y_max_q <= y_max_d;
            found_q <= found_d;
            lost_q  <= lost_d;
            miss_q  <= miss_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    assign o_valid   = (state_q == PUBLISH);
    assign o_x_min   = x_min_q;
    assign o_x_max   = x_max_q;
    assign o_y_min   = y_min_q;
    assign o_y_max   = y_max_q;
    assign o_found   = found_q;
    assign o_lost    = lost_q;
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
    assign err_cnt   = err_q;

endmodule

// File: doc/bbox_ctrl.md
BBOX_CTRL -- requirements
Module: bbox_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 720, active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 576, active lines per frame.
REQ-003 SHALL have parameter MIN_SIZE, default 4, minimum box width and height in pixels.
REQ-004 SHALL have parameter LOST_FRAMES, default 8, number of consecutive misses before the target is declared lost.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  controller run enable.
REQ-008 vsync, de  in  1 each  video timing; vsync high during frame, de high on active pixel.
REQ-009 bb_x_min, bb_x_max, bb_y_min, bb_y_max  in  10 each  bounding-box engine results, updated on the cycle after vsync falls.
REQ-010 o_valid  out  1 / o_ready  in  1  result handshake.
REQ-011 o_x_min, o_x_max, o_y_min, o_y_max  out  10 each  published box.
REQ-012 o_found  out  1  published box is a valid detection.
REQ-013 o_lost  out  1  LOST_FRAMES consecutive misses.
REQ-014 frame_cnt  out  16  good frames evaluated, wraps at 65535->0.
REQ-015 drop_cnt, err_cnt  out  8 each  frames dropped (handshake stall) / frames with bad pixel count; both saturate at 255.

Function
REQ-016 SHALL detect eof as vsync registered 1 and current 0, and sof as registered 0 and current 1.
REQ-017 SHALL implement FSM states IDLE, WAIT_SOF, ACTIVE, CAPTURE, EVAL, PUBLISH.
REQ-018 IDLE -> WAIT_SOF when enable=1; any state -> IDLE on the cycle after enable=0 is sampled, with o_valid deasserted and counters held.
REQ-019 WAIT_SOF -> ACTIVE on sof; the de pixel counter (20 bits) clears on sof.
REQ-020 ACTIVE: pixel counter increments on each de=1 cycle while vsync=1; -> CAPTURE on eof.
REQ-021 CAPTURE: one-cycle wait so engine outputs are settled; -> EVAL.
REQ-022 EVAL: if pixel count != IMG_W*IMG_H, increment err_cnt, leave box/miss state unchanged, go to WAIT_SOF with no publish.
REQ-023 EVAL on good frame: found = (bb_x_max >= bb_x_min) and (bb_y_max >= bb_y_min) and (bb_x_max-bb_x_min+1 >= MIN_SIZE) and (bb_y_max-bb_y_min+1 >= MIN_SIZE), computed at 11 bits without overflow; increment frame_cnt; -> PUBLISH.
REQ-024 found=1: register bb_* into o_*, o_found=1, miss counter=0, o_lost=0.
REQ-025 found=0: o_* keep last found box, o_found=0, miss counter increments saturating at LOST_FRAMES; o_lost=1 when it equals LOST_FRAMES, and o_* are forced to 0 then.
REQ-026 PUBLISH: o_valid=1; o_* and o_found SHALL be stable while o_valid=1 and o_ready=0.
REQ-027 Transfer when o_valid=1 and o_ready=1; o_valid drops next cycle; -> ACTIVE if vsync=1 else WAIT_SOF.
REQ-028 Each eof seen while in PUBLISH SHALL increment drop_cnt; that frame is not evaluated.
REQ-029 o_valid SHALL be 1 only in PUBLISH; latency from eof to o_valid SHALL be exactly 3 cycles.
REQ-030 sof seen in ACTIVE (missed eof) SHALL restart pixel counting without evaluation.

Reset
REQ-031 rst low SHALL asynchronously force state IDLE, o_valid=0, o_*=0, o_found=0, o_lost=0, miss counter=0, frame_cnt=0, drop_cnt=0, err_cnt=0, pixel count=0, vsync register=0.
REQ-032 Reset asserted mid-frame or mid-handshake SHALL abandon the pending result; operation resumes at the next sof after rst high and enable=1.

Verification
REQ-033 Full 720x576 frame, bb=(100,200,50,80), o_ready=1 -> o_valid 3 cycles after eof, o_*=(100,200,50,80), o_found=1, frame_cnt=1.
REQ-034 Empty frame, bb_x_min=720, bb_x_max=0 -> o_found=0, previous box retained; 8 such frames -> o_lost=1, o_*=0.
REQ-035 bb width 3 (x 10..12) -> o_found=0; width 4 (x 10..13) -> o_found=1.
REQ-036 o_ready=0 across two further eofs -> o_* stable, drop_cnt=2; o_ready=1 -> single transfer.
REQ-037 Frame with 719x576 de pulses -> err_cnt=1, no o_valid, frame_cnt unchanged.
REQ-038 rst low during PUBLISH -> o_valid=0 immediately, all counters 0; enable=0 mid-frame -> IDLE next cycle.
